// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX arbiter state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] ARB_S_ARB       = 2'd0;
  localparam logic [1:0] ARB_S_ISSUE     = 2'd1;
  localparam logic [1:0] ARB_S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ARB_S_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_ARB       = ARB_S_ARB,
    ST_ISSUE     = ARB_S_ISSUE,
    ST_WAIT_BUSY = ARB_S_WAIT_BUSY,
    ST_WAIT_DONE = ARB_S_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of mask_i searching upward
// from ptr_i, wrapping modulo NUM_REQ.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    int j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ sources,
// with packet locking and an optional lock timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic                           clk_50m,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_din,
  output logic                           tx_wr_en,
  input  logic                           tx_busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           active
);

  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        lock_id_q, lock_id_d;
  logic                   lock_valid_q, lock_valid_d;
  logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic [UART_BYTE_W-1:0] tx_din_q, tx_din_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]     owner_mask;
  logic [NUM_REQ-1:0]     elig;
  logic                   owner_valid;
  logic                   found;
  logic [ID_W-1:0]        winner;
  logic [UART_BYTE_W-1:0] win_data;
  logic                   win_last;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  always_comb begin
    owner_mask            = '0;
    owner_mask[lock_id_q] = 1'b1;
  end

  // While a packet is locked only its owner may be granted.
  assign elig        = lock_valid_q ? (req_valid & owner_mask) : req_valid;
  assign owner_valid = |(req_valid & owner_mask);

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .mask_i  (elig),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (winner)
  );

  assign win_data = req_data[int'(winner)*UART_BYTE_W +: UART_BYTE_W];
  assign win_last = req_last[winner];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_id_d    = lock_id_q;
    lock_valid_d = lock_valid_q;
    to_cnt_d     = to_cnt_q;
    tx_din_d     = tx_din_q;
    grant_id_d   = grant_id_q;
    req_ready    = '0;
    unique case (state_q)
      ST_ARB: begin
        if (!tx_busy && found) begin
          req_ready[winner] = 1'b1;
          tx_din_d          = win_data;
          grant_id_d        = winner;
          to_cnt_d          = '0;
          if (win_last) begin
            lock_valid_d = 1'b0;
            rr_ptr_d     = next_id(winner);
          end else begin
            lock_valid_d = 1'b1;
            lock_id_d    = winner;
          end
          state_d = ST_ISSUE;
        end else if (LOCK_TIMEOUT > 0 && lock_valid_q && !owner_valid) begin
          // Stalled owner: give up the lock and resume fairness after it.
          if (to_cnt_q == TO_LAST) begin
            lock_valid_d = 1'b0;
            rr_ptr_d     = next_id(lock_id_q);
            to_cnt_d     = '0;
          end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_ARB;
      default:      state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      lock_valid_q <= 1'b0;
      to_cnt_q     <= '0;
      tx_din_q     <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_id_q    <= lock_id_d;
      lock_valid_q <= lock_valid_d;
      to_cnt_q     <= to_cnt_d;
      tx_din_q     <= tx_din_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign tx_din   = tx_din_q;
  assign tx_wr_en = (state_q == ST_ISSUE);
  assign grant_id = grant_id_q;
  assign active   = (state_q != ST_ARB) || lock_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a model transmitter and a
// grant/issue scoreboard, plus hand-written multi-cycle corner cases.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int LOCK_TO  = 16;
  localparam int BUSY_LEN = 10;

  logic                 clk_50m = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_din;
  logic                 tx_wr_en;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_din    (tx_din),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #10 clk_50m = ~clk_50m;

  // Model transmitter: busy for BUSY_LEN cycles starting the cycle after a write.
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  always @(posedge clk_50m) begin
    if (tx_wr_en) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  typedef struct { int id; logic [7:0] data; logic last; } byte_t;
  typedef struct { int id; logic [7:0] data; int cyc; } xfer_t;
  typedef struct { int grp; int id; logic [7:0] data; logic last; } stim_t;
  typedef struct { int grp; int id; logic [7:0] data; } exp_t;

  byte_t rq[$];
  xfer_t exp_q[$];
  xfer_t pend_q[$];
  stim_t stim_tbl[12];
  exp_t  exp_tbl[12];
  int    hs_cyc[NUM_REQ];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present the oldest queued byte of each requester on its port.
  task automatic refresh();
    logic [NUM_REQ-1:0]   v;
    logic [8*NUM_REQ-1:0] d;
    logic [NUM_REQ-1:0]   l;
    v = '0; d = '0; l = '0;
    for (int i = rq.size() - 1; i >= 0; i--) begin
      v[rq[i].id]            = 1'b1;
      d[rq[i].id*8 +: 8]     = rq[i].data;
      l[rq[i].id]            = rq[i].last;
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  initial begin
    forever begin
      @(posedge clk_50m);
      #1;
      refresh();
    end
  end

  // Monitor: protocol rules, grant order against exp_q, issue against pend_q.
  always @(negedge clk_50m) begin
    xfer_t e;
    xfer_t p;
    if (!rst) begin
      checks++;
      if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0) ||
          (|req_ready && tx_busy) || (tx_wr_en && tx_busy)) begin
        errors++;
        $display("FAIL protocol cyc=%0d: ready=%b valid=%b wr_en=%b busy=%b, required one-hot ready within valid and no accept/write while busy",
                 cyc, req_ready, req_valid, tx_wr_en, tx_busy);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        hs_cyc[i] = cyc;
        for (int k = 0; k < rq.size(); k++) begin
          if (rq[k].id == i) begin
            rq.delete(k);
            break;
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant cyc=%0d: got req%0d data=%h, required no grant", cyc, i, req_data[i*8 +: 8]);
        end else begin
          e = exp_q.pop_front();
          if (e.id != i || e.data != req_data[i*8 +: 8]) begin
            errors++;
            $display("FAIL grant cyc=%0d: got req%0d data=%h, required req%0d data=%h",
                     cyc, i, req_data[i*8 +: 8], e.id, e.data);
          end
        end
        pend_q.push_back('{i, req_data[i*8 +: 8], cyc});
      end
    end
    if (tx_wr_en) begin
      checks++;
      if (pend_q.size() == 0) begin
        errors++;
        $display("FAIL issue cyc=%0d: got wr_en din=%h, required no write", cyc, tx_din);
      end else begin
        p = pend_q.pop_front();
        if (tx_din != p.data || grant_id != ID_W'(p.id) || cyc != p.cyc + 1) begin
          errors++;
          $display("FAIL issue: got din=%h id=%0d cyc=%0d, required din=%h id=%0d cyc=%0d",
                   tx_din, grant_id, cyc, p.data, p.id, p.cyc + 1);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    @(negedge clk_50m);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_tx_din"},    int'(tx_din),    0);
    chk({tag, "_tx_wr_en"},  int'(tx_wr_en),  0);
    chk({tag, "_grant_id"},  int'(grant_id),  0);
    chk({tag, "_active"},    int'(active),    0);
  endtask

  task automatic do_reset();
    @(posedge clk_50m); #1;
    rst = 1'b1;
    rq.delete(); exp_q.delete(); pend_q.delete();
    refresh();
    @(posedge clk_50m); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0 || rq.size() != 0 || tx_busy) && n < 1000) begin
      @(posedge clk_50m); #1;
      n++;
    end
    chk({name, "_drained"}, (n >= 1000) ? -1 : (exp_q.size() + pend_q.size() + rq.size()), 0);
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last, input logic expect_it);
    rq.push_back('{id, data, last});
    if (expect_it) exp_q.push_back('{id, data, 0});
  endtask

  task automatic run_group(input int g, input string name);
    @(posedge clk_50m); #1;
    for (int i = 0; i < 12; i++)
      if (stim_tbl[i].grp == g) rq.push_back('{stim_tbl[i].id, stim_tbl[i].data, stim_tbl[i].last});
    for (int i = 0; i < 12; i++)
      if (exp_tbl[i].grp == g) exp_q.push_back('{exp_tbl[i].id, exp_tbl[i].data, 0});
    refresh();
    wait_drain(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int ready_seen;
    int rel_cyc;
    int t_lock;

    // Group 0: single byte. Group 1: round robin from rr_ptr 0.
    // Group 2: starts at rr_ptr 1; req1 moves the pointer to 2, then req2's
    // three-byte packet is locked through, then search restarts at 3 -> req0.
    stim_tbl[0]  = '{0, 0, 8'hA5, 1'b1};
    stim_tbl[1]  = '{1, 0, 8'h10, 1'b1};
    stim_tbl[2]  = '{1, 1, 8'h11, 1'b1};
    stim_tbl[3]  = '{1, 2, 8'h12, 1'b1};
    stim_tbl[4]  = '{1, 3, 8'h13, 1'b1};
    stim_tbl[5]  = '{1, 0, 8'h14, 1'b1};
    stim_tbl[6]  = '{2, 1, 8'h31, 1'b1};
    stim_tbl[7]  = '{2, 1, 8'h51, 1'b1};
    stim_tbl[8]  = '{2, 2, 8'h41, 1'b0};
    stim_tbl[9]  = '{2, 2, 8'h42, 1'b0};
    stim_tbl[10] = '{2, 2, 8'h43, 1'b1};
    stim_tbl[11] = '{2, 0, 8'h50, 1'b1};
    exp_tbl[0]   = '{0, 0, 8'hA5};
    exp_tbl[1]   = '{1, 0, 8'h10};
    exp_tbl[2]   = '{1, 1, 8'h11};
    exp_tbl[3]   = '{1, 2, 8'h12};
    exp_tbl[4]   = '{1, 3, 8'h13};
    exp_tbl[5]   = '{1, 0, 8'h14};
    exp_tbl[6]   = '{2, 1, 8'h31};
    exp_tbl[7]   = '{2, 2, 8'h41};
    exp_tbl[8]   = '{2, 2, 8'h42};
    exp_tbl[9]   = '{2, 2, 8'h43};
    exp_tbl[10]  = '{2, 0, 8'h50};
    exp_tbl[11]  = '{2, 1, 8'h51};

    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");

    run_group(0, "single");
    do_reset();
    run_group(1, "round_robin");
    run_group(2, "lock");

    // Lock timeout: req1 locks then goes idle; req3 waits out the timeout.
    do_reset();
    @(posedge clk_50m); #1;
    push_byte(1, 8'h61, 1'b0, 1'b1);
    push_byte(3, 8'h63, 1'b1, 1'b1);
    refresh();
    wait_drain("timeout");
    // Grant T, frame busy T+2..T+1+BUSY_LEN, first ARB cycle T+3+BUSY_LEN,
    // then LOCK_TO idle ARB cycles before req3 can win.
    chk("timeout_gap", hs_cyc[3] - hs_cyc[1], 3 + BUSY_LEN + LOCK_TO);

    // Reset in WAIT_DONE while req2 holds a lock.
    do_reset();
    @(posedge clk_50m); #1;
    push_byte(2, 8'h71, 1'b0, 1'b1);
    refresh();
    n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 100) begin
      @(posedge clk_50m); #1;
      n++;
    end
    t_lock = hs_cyc[2];
    repeat (3) @(posedge clk_50m);
    #1;
    chk("midrst_active_before", int'(active), 1);
    rst = 1'b1;
    @(posedge clk_50m); #1;
    rst = 1'b0;
    push_byte(0, 8'h80, 1'b1, 1'b1);
    refresh();
    check_reset_vals("midrst");
    wait_drain("midrst");
    chk("midrst_grant_at_idle", hs_cyc[0], t_lock + 2 + BUSY_LEN);

    // Transmitter busy when reset releases.
    @(posedge clk_50m); #1;
    busy_force = 1'b1;
    rst = 1'b1;
    @(posedge clk_50m); #1;
    rst = 1'b0;
    push_byte(0, 8'h90, 1'b1, 1'b1);
    refresh();
    ready_seen = 0;
    repeat (5) begin
      @(negedge clk_50m);
      if (req_ready != '0) ready_seen++;
    end
    chk("busy_start_no_ready", ready_seen, 0);
    @(posedge clk_50m); #1;
    busy_force = 1'b0;
    rel_cyc = cyc;
    wait_drain("busy_start");
    chk("busy_start_grant", hs_cyc[0], rel_cyc);

    repeat (2) @(posedge clk_50m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
